// File: rtl/jtag_pkg.sv
// Shared types and helpers for the JTAG data-register bank.
package jtag_pkg;

    localparam int unsigned DEFAULT_ID_WIDTH = 32;
    localparam int unsigned DEFAULT_BSR_LEN  = 8;

    localparam logic [31:0] IDCODE_DEFAULT   = 32'h1A2B_3C4D;
    localparam logic [31:0] USERCODE_DEFAULT = 32'h0000_00A1;

    // Data register currently placed between TDI and TDO
    typedef enum logic [1:0] {
        DR_BYPASS   = 2'd0,
        DR_IDCODE   = 2'd1,
        DR_USERCODE = 2'd2,
        DR_BSR      = 2'd3
    } dr_sel_e;

    // Decoded instruction lines to DR target; IDCODE beats USERCODE beats the
    // boundary instructions, everything else (CLAMP, HIGHZ, BYPASS, none) is BYPASS
    function automatic dr_sel_e dr_select(
        input logic idcode_sel,
        input logic usercode_sel,
        input logic sample_sel,
        input logic extest_sel,
        input logic intest_sel
    );
        dr_sel_e sel;
        sel = DR_BYPASS;
        if (idcode_sel) begin
            sel = DR_IDCODE;
        end else if (usercode_sel) begin
            sel = DR_USERCODE;
        end else if (sample_sel || extest_sel || intest_sel) begin
            sel = DR_BSR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/jtag_dr_shreg.sv
// Generic capture/shift data register; TDI enters the MSB, LSB exits first.
module jtag_dr_shreg
    import jtag_pkg::*;
#(
    parameter int unsigned       WIDTH           = 1,
    parameter logic [WIDTH-1:0]  CAPTURE_DEFAULT = '0
) (
    input  logic             TCK,
    input  logic             rst,
    input  logic             capture_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] capture_data,
    input  logic             TDI,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Capture has priority over shift; otherwise the register holds
    always_comb begin
        q_d = q_q;
        if (capture_en) begin
            q_d = capture_data;
        end else if (shift_en) begin
            q_d = (q_q >> 1) | (WIDTH'(TDI) << (WIDTH - 1));
        end
    end

    // Register state; reset restores the capture default
    always_ff @(posedge TCK) begin
        if (!rst) begin
            q_q <= CAPTURE_DEFAULT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE, USERCODE and boundary scan,
// the boundary update latch, pin/core muxes and falling-edge TDO.
module jtag_dr_bank
    import jtag_pkg::*;
#(
    parameter int unsigned          BSR_LEN        = DEFAULT_BSR_LEN,
    parameter int unsigned          ID_WIDTH       = DEFAULT_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0]  IDCODE_VALUE   = ID_WIDTH'(IDCODE_DEFAULT),
    parameter logic [ID_WIDTH-1:0]  USERCODE_VALUE = ID_WIDTH'(USERCODE_DEFAULT)
) (
    input  logic               TCK,
    input  logic               rst,
    input  logic               TDI,
    input  logic               CAPTUREDR,
    input  logic               SHIFTDR,
    input  logic               UPDATEDR,
    input  logic               BYPASS_SELECT,
    input  logic               SAMPLE_SELECT,
    input  logic               EXTEST_SELECT,
    input  logic               INTEST_SELECT,
    input  logic               CLAMP_SELECT,
    input  logic               IDCODE_SELECT,
    input  logic               USERCODE_SELECT,
    input  logic               HIGHZ_SELECT,
    input  logic [BSR_LEN-1:0] PIN_IN,
    input  logic [BSR_LEN-1:0] CORE_OUT,
    output logic [BSR_LEN-1:0] PIN_OUT,
    output logic               PIN_OE,
    output logic [BSR_LEN-1:0] CORE_IN,
    output logic [BSR_LEN-1:0] BSR_UPD,
    output logic               TDO
);

    // Parameter sanity; a bad configuration stops elaboration
    if (BSR_LEN < 1) begin : g_bad_bsr_len
        $error("jtag_dr_bank: BSR_LEN must be at least 1");
    end
    if (ID_WIDTH < 2) begin : g_bad_id_width
        $error("jtag_dr_bank: ID_WIDTH must be at least 2");
    end
    if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_dr_bank: IDCODE_VALUE bit 0 must be 1");
    end

    dr_sel_e            sel_c;
    logic               shift_c;

    logic               bypass_cap_c;
    logic               bypass_shift_c;
    logic               idcode_cap_c;
    logic               idcode_shift_c;
    logic               usercode_cap_c;
    logic               usercode_shift_c;
    logic               bsr_cap_c;
    logic               bsr_shift_c;
    logic [BSR_LEN-1:0] bsr_cap_data_c;

    logic [0:0]          bypass_sr;
    logic [ID_WIDTH-1:0] idcode_sr;
    logic [ID_WIDTH-1:0] usercode_sr;
    logic [BSR_LEN-1:0]  bsr_sr;

    logic [BSR_LEN-1:0] bsr_upd_q;
    logic [BSR_LEN-1:0] bsr_upd_d;
    logic               tdo_q;
    logic               tdo_d;

    // Only the upper ID bits feed nothing but the serial chain; BYPASS_SELECT
    // is implied by the absence of any other DR-selecting instruction
    logic               dr_unused;
    assign dr_unused = ^{idcode_sr[ID_WIDTH-1:1], usercode_sr[ID_WIDTH-1:1], BYPASS_SELECT};

    // Decode the active DR and per-register capture/shift strobes
    always_comb begin
        sel_c            = dr_select(IDCODE_SELECT, USERCODE_SELECT,
                                     SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT);
        shift_c          = SHIFTDR && !CAPTUREDR;
        bypass_cap_c     = CAPTUREDR && (sel_c == DR_BYPASS);
        bypass_shift_c   = shift_c   && (sel_c == DR_BYPASS);
        idcode_cap_c     = CAPTUREDR && (sel_c == DR_IDCODE);
        idcode_shift_c   = shift_c   && (sel_c == DR_IDCODE);
        usercode_cap_c   = CAPTUREDR && (sel_c == DR_USERCODE);
        usercode_shift_c = shift_c   && (sel_c == DR_USERCODE);
        bsr_cap_c        = CAPTUREDR && (sel_c == DR_BSR);
        bsr_shift_c      = shift_c   && (sel_c == DR_BSR);
        bsr_cap_data_c   = (SAMPLE_SELECT || EXTEST_SELECT) ? PIN_IN : CORE_OUT;
    end

    jtag_dr_shreg #(
        .WIDTH           (1),
        .CAPTURE_DEFAULT (1'b0)
    ) u_bypass (
        .TCK          (TCK),
        .rst          (rst),
        .capture_en   (bypass_cap_c),
        .shift_en     (bypass_shift_c),
        .capture_data (1'b0),
        .TDI          (TDI),
        .q            (bypass_sr)
    );

    jtag_dr_shreg #(
        .WIDTH           (ID_WIDTH),
        .CAPTURE_DEFAULT (IDCODE_VALUE)
    ) u_idcode (
        .TCK          (TCK),
        .rst          (rst),
        .capture_en   (idcode_cap_c),
        .shift_en     (idcode_shift_c),
        .capture_data (IDCODE_VALUE),
        .TDI          (TDI),
        .q            (idcode_sr)
    );

    jtag_dr_shreg #(
        .WIDTH           (ID_WIDTH),
        .CAPTURE_DEFAULT (USERCODE_VALUE)
    ) u_usercode (
        .TCK          (TCK),
        .rst          (rst),
        .capture_en   (usercode_cap_c),
        .shift_en     (usercode_shift_c),
        .capture_data (USERCODE_VALUE),
        .TDI          (TDI),
        .q            (usercode_sr)
    );

    jtag_dr_shreg #(
        .WIDTH           (BSR_LEN),
        .CAPTURE_DEFAULT ('0)
    ) u_bsr (
        .TCK          (TCK),
        .rst          (rst),
        .capture_en   (bsr_cap_c),
        .shift_en     (bsr_shift_c),
        .capture_data (bsr_cap_data_c),
        .TDI          (TDI),
        .q            (bsr_sr)
    );

    // Boundary update latch: loads only on Update-DR with the BSR selected
    always_comb begin
        bsr_upd_d = bsr_upd_q;
        if (UPDATEDR && (sel_c == DR_BSR)) begin
            bsr_upd_d = bsr_sr;
        end
    end

    // Update latch state
    always_ff @(posedge TCK) begin
        if (!rst) begin
            bsr_upd_q <= '0;
        end else begin
            bsr_upd_q <= bsr_upd_d;
        end
    end

    // Serial output source: LSB of the selected register
    always_comb begin
        tdo_d = bypass_sr[0];
        case (sel_c)
            DR_IDCODE:   tdo_d = idcode_sr[0];
            DR_USERCODE: tdo_d = usercode_sr[0];
            DR_BSR:      tdo_d = bsr_sr[0];
            default:     tdo_d = bypass_sr[0];
        endcase
    end

    // TDO launches on the falling edge so the host samples a stable bit
    always_ff @(negedge TCK) begin
        if (!rst) begin
            tdo_q <= 1'b0;
        end else begin
            tdo_q <= tdo_d;
        end
    end

    // Pin/core boundary muxes
    assign PIN_OUT = (EXTEST_SELECT || CLAMP_SELECT) ? bsr_upd_q : CORE_OUT;
    assign CORE_IN = INTEST_SELECT ? bsr_upd_q : PIN_IN;
    assign PIN_OE  = ~HIGHZ_SELECT;
    assign BSR_UPD = bsr_upd_q;
    assign TDO     = tdo_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Scoreboard bench for jtag_dr_bank: stimulus pushes model expectations,
// a monitor pops and compares once per falling edge.
module tb_jtag_dr_bank;

    localparam logic [31:0] IDV = 32'h1A2B_3C4D;
    localparam logic [31:0] UCV = 32'h0000_00A1;

    localparam int I_BYP  = 0;
    localparam int I_ID   = 1;
    localparam int I_UC   = 2;
    localparam int I_SMP  = 3;
    localparam int I_EXT  = 4;
    localparam int I_INT  = 5;
    localparam int I_CLMP = 6;
    localparam int I_HIZ  = 7;
    localparam int I_NONE = 8;
    localparam int I_IDUC = 9;

    localparam int S_BYP = 0;
    localparam int S_ID  = 1;
    localparam int S_UC  = 2;
    localparam int S_BSR = 3;

    logic       TCK, rst, TDI, CAPTUREDR, SHIFTDR, UPDATEDR;
    logic       BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT;
    logic       CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT;
    logic [7:0] PIN_IN, CORE_OUT, PIN_OUT, CORE_IN, BSR_UPD;
    logic       PIN_OE, TDO;

    jtag_dr_bank dut (
        .TCK(TCK), .rst(rst), .TDI(TDI),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
        .BYPASS_SELECT(BYPASS_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
        .EXTEST_SELECT(EXTEST_SELECT), .INTEST_SELECT(INTEST_SELECT),
        .CLAMP_SELECT(CLAMP_SELECT), .IDCODE_SELECT(IDCODE_SELECT),
        .USERCODE_SELECT(USERCODE_SELECT), .HIGHZ_SELECT(HIGHZ_SELECT),
        .PIN_IN(PIN_IN), .CORE_OUT(CORE_OUT),
        .PIN_OUT(PIN_OUT), .PIN_OE(PIN_OE), .CORE_IN(CORE_IN),
        .BSR_UPD(BSR_UPD), .TDO(TDO)
    );

    typedef struct {
        logic       tdo;
        logic [7:0] pin_out;
        logic [7:0] core_in;
        logic [7:0] bsr_upd;
        logic       pin_oe;
    } exp_t;

    exp_t exp_q[$];

    int   checks = 0;
    int   passes = 0;
    logic last_tdo = 1'b0;
    bit   tdo_known = 1'b0;

    // Reference model state
    logic        m_byp;
    logic [31:0] m_id, m_uc;
    logic [7:0]  m_bsr, m_upd;

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
        end else begin
            passes++;
        end
    endtask

    // Drop the decoded instruction lines to a single instruction
    task automatic set_instr(input int code);
        BYPASS_SELECT   = (code == I_BYP);
        IDCODE_SELECT   = (code == I_ID) || (code == I_IDUC);
        USERCODE_SELECT = (code == I_UC) || (code == I_IDUC);
        SAMPLE_SELECT   = (code == I_SMP);
        EXTEST_SELECT   = (code == I_EXT);
        INTEST_SELECT   = (code == I_INT);
        CLAMP_SELECT    = (code == I_CLMP);
        HIGHZ_SELECT    = (code == I_HIZ);
    endtask

    function automatic int model_sel();
        if (IDCODE_SELECT) return S_ID;
        if (USERCODE_SELECT) return S_UC;
        if (SAMPLE_SELECT || EXTEST_SELECT || INTEST_SELECT) return S_BSR;
        return S_BYP;
    endfunction

    // One TCK cycle: drive, advance the model, queue the expected outputs
    task automatic cyc(input logic r, input logic cap, input logic sh,
                       input logic upd, input logic tdi);
        int   s;
        exp_t e;
        rst = r; CAPTUREDR = cap; SHIFTDR = sh; UPDATEDR = upd; TDI = tdi;
        s = model_sel();
        if (!r) begin
            m_byp = 1'b0; m_bsr = 8'h00; m_upd = 8'h00; m_id = IDV; m_uc = UCV;
        end else begin
            if (upd && s == S_BSR) m_upd = m_bsr;
            if (cap) begin
                case (s)
                    S_ID:    m_id = IDV;
                    S_UC:    m_uc = UCV;
                    S_BSR:   m_bsr = INTEST_SELECT ? CORE_OUT : PIN_IN;
                    default: m_byp = 1'b0;
                endcase
            end else if (sh) begin
                case (s)
                    S_ID:    m_id  = (m_id / 2) + (tdi ? 32'h8000_0000 : 32'h0);
                    S_UC:    m_uc  = (m_uc / 2) + (tdi ? 32'h8000_0000 : 32'h0);
                    S_BSR:   m_bsr = (m_bsr / 2) + (tdi ? 8'h80 : 8'h00);
                    default: m_byp = tdi;
                endcase
            end
        end
        case (s)
            S_ID:    e.tdo = m_id[0];
            S_UC:    e.tdo = m_uc[0];
            S_BSR:   e.tdo = m_bsr[0];
            default: e.tdo = m_byp;
        endcase
        if (!r) e.tdo = 1'b0;
        e.pin_out = (EXTEST_SELECT || CLAMP_SELECT) ? m_upd : CORE_OUT;
        e.core_in = INTEST_SELECT ? m_upd : PIN_IN;
        e.bsr_upd = m_upd;
        e.pin_oe  = !HIGHZ_SELECT;
        exp_q.push_back(e);
        @(negedge TCK);
        #3;
    endtask

    task automatic shift_byte(input logic [7:0] v);
        logic [7:0] b;
        b = v;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, b[i]);
    endtask

    // Monitor: TDO and all registered/muxed outputs settle by just after the falling edge
    initial begin
        forever begin
            @(negedge TCK);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tdo",     32'(TDO),     32'(e.tdo));
                chk("pin_out", 32'(PIN_OUT), 32'(e.pin_out));
                chk("core_in", 32'(CORE_IN), 32'(e.core_in));
                chk("bsr_upd", 32'(BSR_UPD), 32'(e.bsr_upd));
                chk("pin_oe",  32'(PIN_OE),  32'(e.pin_oe));
                last_tdo  = e.tdo;
                tdo_known = 1'b1;
            end
        end
    end

    // TDO must not move on the rising edge
    initial begin
        forever begin
            @(posedge TCK);
            #1;
            if (tdo_known) chk("tdo_rise_hold", 32'(TDO), 32'(last_tdo));
        end
    end

    initial begin
        int instr;
        int budget;
        rst = 1'b0; TDI = 1'b0; CAPTUREDR = 1'b0; SHIFTDR = 1'b0; UPDATEDR = 1'b0;
        PIN_IN = 8'h00; CORE_OUT = 8'h00;
        set_instr(I_NONE);
        m_byp = 1'b0; m_bsr = 8'h00; m_upd = 8'h00; m_id = IDV; m_uc = UCV;
        @(negedge TCK);
        #3;

        // Reset
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // IDCODE capture then 32 shifts of zero
        set_instr(I_ID);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (32) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // BYPASS: one-cycle delay of 1,0,1,1
        set_instr(I_BYP);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // SAMPLE/preload: capture 5C, shift in A3, update
        PIN_IN = 8'h5C; CORE_OUT = 8'h3E;
        set_instr(I_SMP);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_byte(8'hA3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // EXTEST drives the preloaded value, CLAMP keeps it with BYPASS on TDO
        set_instr(I_EXT);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_instr(I_CLMP);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // INTEST: capture core 0F, shift F0, update onto core inputs
        CORE_OUT = 8'h0F; PIN_IN = 8'h66;
        set_instr(I_INT);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_byte(8'hF0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_instr(I_HIZ);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an EXTEST shift
        set_instr(I_EXT);
        PIN_IN = 8'hC7;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // IDCODE and USERCODE together: IDCODE wins
        set_instr(I_IDUC);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Select change mid-shift, and capture beating shift
        set_instr(I_UC);
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        set_instr(I_ID);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Randomised traffic
        instr = I_BYP;
        for (int n = 0; n < 400; n++) begin
            if ((n % 16) == 0) instr = int'($urandom_range(0, 9));
            set_instr(instr);
            PIN_IN   = 8'($urandom);
            CORE_OUT = 8'($urandom);
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 7) == 0),
                1'($urandom));
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge TCK);
            #2;
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
